ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Parametrised fetch unit: one outstanding icache request, pre-decode of JAL/BRANCH/JALR,
//  predictor query, decoupled QDEPTH-entry instruction queue to decoder (valid/ready).
//  Sits between icache/predictor and decoder/ROB; ROB redirect flushes queue and in-flight fetch.
// PARAMETERS
//  QDEPTH    4   instruction queue entries (power of 2, >=2)
//  RESET_PC  0   fetch PC after reset
// PORTS
//  clk_in        in   1   clock
//  rst_n_in      in   1   asynchronous reset, active low
//  rdy_in        in   1   0 = freeze all state (outputs held)
//  icache_req    out  1   1-cycle fetch request pulse
//  icache_pc     out  32  request address
//  icache_valid  in   1   response valid (>=1 cycle after req)
//  icache_inst   in   32  response instruction
//  pred_query    out  1   predictor lookup pulse
//  pred_pc       out  32  lookup address
//  pred_taken    in   1   prediction, valid cycle after pred_query
//  upd_valid     out  1   predictor update pulse
//  upd_pc        out  32  resolved branch PC
//  upd_taken     out  1   resolved branch outcome
//  dec_valid     out  1   queue head valid
//  dec_inst      out  32  head instruction
//  dec_pc        out  32  head PC
//  dec_pred      out  1   head predicted-taken (0 for non-branch)
//  dec_ready     in   1   decoder accepts head
//  redirect      in   1   ROB flush (mispredict)
//  redirect_pc   in   32  flush target
//  jalr_done     in   1   JALR target resolved
//  jalr_target   in   32  JALR target
//  br_done       in   1   branch resolved
//  br_pc         in   32  branch PC
//  br_taken      in   1   branch outcome
// BEHAVIOUR
//  Reset: all outputs 0, pc=RESET_PC, queue empty, state FETCH.
//  States: FETCH, WAIT, PRED, JSTALL, DROP.
//  FETCH: if count<QDEPTH: icache_req=1, icache_pc=pc, ->WAIT; else stay.
//  WAIT, icache_valid, opcode=icache_inst[6:0]:
//   1101111 JAL: push, pc+=sext J-imm, ->FETCH.
//   1100011 BR: hold inst, pred_query=1, pred_pc=pc, ->PRED.
//   1100111 JALR: push, ->JSTALL.  other: push, pc+=4, ->FETCH.
//  PRED: push with dec_pred=pred_taken; pc = taken ? pc+sext B-imm : pc+4; ->FETCH.
//  JSTALL: jalr_done -> pc=jalr_target, ->FETCH.
//  DROP: discard next icache_valid (no push), ->FETCH.
//  Queue: FIFO, dec_* driven from head registers; pop on dec_valid&dec_ready; push+pop same
//   cycle legal at any count; count gating guarantees no push when full; PC adds wrap mod 2^32.
//  redirect (highest priority, any state): queue flushed, pc=redirect_pc, pending pred dropped;
//   ->DROP if in WAIT without icache_valid this cycle, else ->FETCH. In DROP stays DROP.
//   Same-cycle jalr_done or push ignored; a pop that cycle still completes.
//  br_done: next cycle upd_valid=1, upd_pc=br_pc, upd_taken=br_taken; independent of redirect.
//  Pulses (icache_req, pred_query, upd_valid) high exactly one active cycle.
//  Async reset mid-request: state cleared; a late icache_valid in FETCH is ignored.
// CONFIGURATION
//  IFETCH_STATIC_PRED_EN defined: no predictor query; BR pushed directly in WAIT with
//   dec_pred = B-imm sign bit (backward taken), PRED unused, pred_query tied 0.
//  Undefined: dynamic prediction via PRED state as above.
// TESTING
//  Reset, 4 ALU insts at 0x0..0xC, dec_ready=1 -> dec_pc 0,4,8,C in order, dec_pred=0.
//  JAL imm=+0x100 at 0x10 -> next icache_pc=0x110.
//  BR at 0x20 imm=-8, pred_taken=1 -> dec_pred=1, next icache_pc=0x18; static mode same w/o query.
//  dec_ready=0, QDEPTH=4 -> exactly 4 requests then icache_req stays 0 until pop.
//  redirect to 0x200 while WAIT -> following icache_valid dropped, next icache_pc=0x200, dec_valid=0.
//  JALR at 0x40, jalr_done target 0x80 -> no req during JSTALL, next icache_pc=0x80.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: icache, predictor, decoder and ROB-side signals.
// master = fetch unit, slave = surrounding pipeline/testbench.
interface ifetch_queue_if;
  logic        icache_req;
  logic [31:0] icache_pc;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic        pred_query;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        jalr_done;
  logic [31:0] jalr_target;
  logic        br_done;
  logic [31:0] br_pc;
  logic        br_taken;

  modport master (
    output icache_req, icache_pc, pred_query, pred_pc,
           upd_valid, upd_pc, upd_taken,
           dec_valid, dec_inst, dec_pc, dec_pred,
    input  icache_valid, icache_inst, pred_taken, dec_ready,
           redirect, redirect_pc, jalr_done, jalr_target,
           br_done, br_pc, br_taken
  );

  modport slave (
    input  icache_req, icache_pc, pred_query, pred_pc,
           upd_valid, upd_pc, upd_taken,
           dec_valid, dec_inst, dec_pc, dec_pred,
    output icache_valid, icache_inst, pred_taken, dec_ready,
           redirect, redirect_pc, jalr_done, jalr_target,
           br_done, br_pc, br_taken
  );
endinterface

// File: rtl/ifetch_queue.sv
// Single-outstanding fetch FSM with JAL/BR/JALR pre-decode and a QDEPTH-entry queue.
// Define IFETCH_STATIC_PRED_EN for backward-taken static branch prediction (no predictor query).
module ifetch_queue #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           rdy_in,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_PRED, S_JSTALL, S_DROP} state_t;

  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        req_q, req_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        pq_q, pq_d;
  logic [31:0] pq_pc_q, pq_pc_d;
  logic        upd_v_q, upd_t_q;
  logic [31:0] upd_pc_q;

  logic [QDEPTH-1:0][31:0] qinst_q, qpc_q;
  logic [QDEPTH-1:0]       qpred_q;
  logic [AW-1:0]           head_q, tail_q;
  logic [AW:0]             cnt_q;

  logic        push, pop, flush, push_pred;
  logic [31:0] push_inst;
  logic [6:0]  opc;

  assign opc = bus.icache_inst[6:0];
  assign pop = (cnt_q != '0) && bus.dec_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_inst_d = hold_inst_q;
    req_d       = 1'b0;
    req_pc_d    = req_pc_q;
    pq_d        = 1'b0;
    pq_pc_d     = pq_pc_q;
    push        = 1'b0;
    push_inst   = bus.icache_inst;
    push_pred   = 1'b0;
    flush       = 1'b0;
    if (bus.redirect) begin
      // The outstanding response must still be swallowed if it has not arrived yet.
      flush   = 1'b1;
      pc_d    = bus.redirect_pc;
      state_d = (state_q == S_DROP || (state_q == S_WAIT && !bus.icache_valid)) ? S_DROP : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: if (int'(cnt_q) < QDEPTH) begin
          req_d    = 1'b1;
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
        S_WAIT: if (bus.icache_valid) begin
          case (opc)
            OP_JAL: begin
              push    = 1'b1;
              pc_d    = pc_q + j_imm(bus.icache_inst);
              state_d = S_FETCH;
            end
            OP_BR: begin
`ifdef IFETCH_STATIC_PRED_EN
              push      = 1'b1;
              push_pred = bus.icache_inst[31];
              pc_d      = bus.icache_inst[31] ? pc_q + b_imm(bus.icache_inst) : pc_q + 32'd4;
              state_d   = S_FETCH;
`else
              hold_inst_d = bus.icache_inst;
              pq_d        = 1'b1;
              pq_pc_d     = pc_q;
              state_d     = S_PRED;
`endif
            end
            OP_JALR: begin
              push    = 1'b1;
              state_d = S_JSTALL;
            end
            default: begin
              push    = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = S_FETCH;
            end
          endcase
        end
        // First PRED cycle is the query itself; the answer is sampled one cycle later.
        S_PRED: if (!pq_q) begin
          push      = 1'b1;
          push_inst = hold_inst_q;
          push_pred = bus.pred_taken;
          pc_d      = bus.pred_taken ? pc_q + b_imm(hold_inst_q) : pc_q + 32'd4;
          state_d   = S_FETCH;
        end
        S_JSTALL: if (bus.jalr_done) begin
          pc_d    = bus.jalr_target;
          state_d = S_FETCH;
        end
        S_DROP: if (bus.icache_valid) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      hold_inst_q <= '0;
      req_q       <= 1'b0;
      req_pc_q    <= '0;
      pq_q        <= 1'b0;
      pq_pc_q     <= '0;
      upd_v_q     <= 1'b0;
      upd_t_q     <= 1'b0;
      upd_pc_q    <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_inst_q <= hold_inst_d;
      req_q       <= req_d;
      req_pc_q    <= req_pc_d;
      pq_q        <= pq_d;
      pq_pc_q     <= pq_pc_d;
      upd_v_q     <= bus.br_done;
      if (bus.br_done) begin
        upd_pc_q <= bus.br_pc;
        upd_t_q  <= bus.br_taken;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      qinst_q <= '0;
      qpc_q   <= '0;
      qpred_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) begin
          qinst_q[tail_q] <= push_inst;
          qpc_q[tail_q]   <= pc_q;
          qpred_q[tail_q] <= push_pred;
          tail_q          <= tail_q + AW'(1);
        end
        if (pop) head_q <= head_q + AW'(1);
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  assign bus.icache_req = req_q;
  assign bus.icache_pc  = req_pc_q;
  assign bus.pred_query = pq_q;
  assign bus.pred_pc    = pq_pc_q;
  assign bus.upd_valid  = upd_v_q;
  assign bus.upd_pc     = upd_pc_q;
  assign bus.upd_taken  = upd_t_q;
  assign bus.dec_valid  = (cnt_q != '0);
  assign bus.dec_inst   = qinst_q[head_q];
  assign bus.dec_pc     = qpc_q[head_q];
  assign bus.dec_pred   = qpred_q[head_q];
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: behavioural icache responder plus request/pop logs.
module tb_ifetch_queue;
  logic clk, rst_n, rdy;
  int   total, bad;
  int   rsp_lat;

  logic [31:0] imem [logic [31:0]];
  logic [31:0] req_log[$], pq_log[$], pop_pc[$], pop_inst[$];
  logic        pop_pred[$];

  ifetch_queue_if bus();
  ifetch_queue #(.QDEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'h0000_0013;
  endfunction

  // icache model + observers, all acting on the falling edge
  initial begin : responder
    logic        pend;
    logic [31:0] pend_pc;
    int          lat;
    pend = 1'b0; pend_pc = '0; lat = 0;
    bus.icache_valid = 1'b0;
    bus.icache_inst  = '0;
    forever begin
      @(negedge clk);
      bus.icache_valid = 1'b0;
      if (!rst_n) pend = 1'b0;
      else if (rdy) begin
        if (pend) begin
          lat--;
          if (lat == 0) begin
            bus.icache_valid = 1'b1;
            bus.icache_inst  = imem_rd(pend_pc);
            pend = 1'b0;
          end
        end
        if (bus.icache_req) begin
          req_log.push_back(bus.icache_pc);
          pend = 1'b1; pend_pc = bus.icache_pc; lat = rsp_lat;
        end
        if (bus.pred_query) pq_log.push_back(bus.pred_pc);
        if (bus.dec_valid && bus.dec_ready) begin
          pop_pc.push_back(bus.dec_pc);
          pop_inst.push_back(bus.dec_inst);
          pop_pred.push_back(bus.dec_pred);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dec_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.jalr_done = 1'b0; bus.jalr_target = '0;
    bus.br_done = 1'b0; bus.br_pc = '0; bus.br_taken = 1'b0;
    bus.pred_taken = 1'b1;
    rsp_lat = 1;
    cyc(2);
    imem.delete();
    req_log.delete(); pq_log.delete();
    pop_pc.delete(); pop_inst.delete(); pop_pred.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_reqs(input string tag, input int n);
    for (int k = 0; k < 200 && req_log.size() < n; k++) cyc(1);
    chk(tag, req_log.size(), n);
  endtask

  task automatic wait_pops(input string tag, input int n);
    for (int k = 0; k < 200 && pop_pc.size() < n; k++) cyc(1);
    chk(tag, pop_pc.size(), n);
  endtask

  initial begin
    total = 0; bad = 0; rdy = 1'b1; rst_n = 1'b1;
    do_reset();
    rst_n = 1'b0;
    cyc(1);
    chk("rst_req",   bus.icache_req, 0);
    chk("rst_dvld",  bus.dec_valid,  0);
    chk("rst_pq",    bus.pred_query, 0);
    chk("rst_upd",   bus.upd_valid,  0);
    chk("rst_dinst", bus.dec_inst,   0);

    // straight-line ALU stream
    do_reset();
    bus.dec_ready = 1'b1;
    wait_pops("alu_pops", 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alu_pc%0d", i),   pop_pc[i],   32'(i * 4));
      chk($sformatf("alu_pred%0d", i), pop_pred[i], 0);
    end
    chk("alu_inst0", pop_inst[0], 32'h0000_0013);

    // JAL +0x100 at 0x10
    do_reset();
    imem[32'h10] = 32'h1000_006F;
    bus.dec_ready = 1'b1;
    wait_reqs("jal_nreq", 6);
    chk("jal_req4", req_log[4], 32'h10);
    chk("jal_req5", req_log[5], 32'h110);

    // JAL to 0x20, then BEQ -8 predicted taken
    do_reset();
    imem[32'h0]  = 32'h0200_006F;
    imem[32'h20] = 32'hFE00_0CE3;
    bus.dec_ready = 1'b1;
    wait_reqs("br_nreq", 3);
    chk("br_req1", req_log[1], 32'h20);
    chk("br_req2", req_log[2], 32'h18);
    wait_pops("br_pops", 3);
    chk("br_pop1pc",   pop_pc[1],   32'h20);
    chk("br_pop1inst", pop_inst[1], 32'hFE00_0CE3);
    chk("br_pop1pred", pop_pred[1], 1);
    chk("br_pop0pred", pop_pred[0], 0);
    chk("br_pop2pc",   pop_pc[2],   32'h18);
`ifdef IFETCH_STATIC_PRED_EN
    chk("br_nquery", pq_log.size(), 0);
`else
    chk("br_nquery", pq_log.size(), 1);
    chk("br_qpc",    pq_log[0],     32'h20);
`endif

    // queue full back-pressure
    do_reset();
    cyc(40);
    chk("full_nreq", req_log.size(), 4);
    chk("full_dvld", bus.dec_valid, 1);
    chk("full_dpc",  bus.dec_pc, 0);
    bus.dec_ready = 1'b1;
    cyc(1);
    bus.dec_ready = 1'b0;
    cyc(10);
    chk("full_nreq2", req_log.size(), 5);
    chk("full_dpc2",  bus.dec_pc, 32'h4);
    chk("full_req4",  req_log[4], 32'h10);

    // redirect while waiting on the icache
    do_reset();
    rsp_lat = 4;
    bus.dec_ready = 1'b1;
    wait_reqs("rd_first", 1);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    cyc(1);
    bus.redirect = 1'b0;
    chk("rd_dvld", bus.dec_valid, 0);
    wait_reqs("rd_nreq", 2);
    chk("rd_req1", req_log[1], 32'h200);
    wait_pops("rd_pops", 1);
    chk("rd_pop0", pop_pc[0], 32'h200);

    // JALR stall
    do_reset();
    imem[32'h0]  = 32'h0400_006F;
    imem[32'h40] = 32'h0000_8067;
    bus.dec_ready = 1'b1;
    wait_reqs("jr_nreq", 2);
    cyc(10);
    chk("jr_stall", req_log.size(), 2);
    chk("jr_req1",  req_log[1], 32'h40);
    bus.jalr_done = 1'b1; bus.jalr_target = 32'h80;
    cyc(1);
    bus.jalr_done = 1'b0;
    wait_reqs("jr_nreq2", 3);
    chk("jr_req2", req_log[2], 32'h80);

    // predictor update pulse and freeze
    bus.br_done = 1'b1; bus.br_pc = 32'h1234; bus.br_taken = 1'b1;
    cyc(1);
    bus.br_done = 1'b0;
    chk("upd_v",  bus.upd_valid, 1);
    chk("upd_pc", bus.upd_pc,    32'h1234);
    chk("upd_t",  bus.upd_taken, 1);
    rdy = 1'b0;
    cyc(1);
    chk("upd_hold", bus.upd_valid, 1);
    rdy = 1'b1;
    cyc(1);
    chk("upd_pulse", bus.upd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
